wmst_result_packer: RTL
=======================

# wmst_result_packer

Packs narrow per-cycle convolution results from the conv engine into DATA_WIDTH-bit AXI-Stream words. Issues the one-shot write-master request (address and byte size) for the output tensor, and signals completion after the write master reports done. Sits directly upstream of engine_control's write path: its outputs drive wmst_req_in_0, wmst_xfer_addr_in_0, wmst_xfer_size_in_0, axis_mst_wmst_tvalid_in_0 and axis_mst_wmst_tdata_in_0. It consumes op_start_0 and axis_mst_wmst_tready_out_0.

## Interface
- DATA_WIDTH, 512, output stream word width in bits.
- RES_WIDTH, 32, width of one conv result; DATA_WIDTH must be an integer multiple of it.
- LANES, DATA_WIDTH/RES_WIDTH, results per output word (16 at defaults).
- WORD_BYTE, DATA_WIDTH/8, bytes per output word.

Ports:
- aclk  in  1  clock.
- areset_n  in  1  asynchronous, active-low reset.
- op_start  in  1  single-cycle start pulse from engine_control.
- cfg_out_addr  in  64  output buffer base byte address; sampled on op_start.
- cfg_out_count  in  32  number of results to write; sampled on op_start.
- res_valid  in  1  result valid from conv engine.
- res_data  in  RES_WIDTH  result value.
- res_ready  out  1  packer accepts result.
- wmst_req  out  1  one-cycle write request pulse.
- wmst_xfer_addr  out  64  latched cfg_out_addr.
- wmst_xfer_size  out  64  byte count, ceil(count/LANES)*WORD_BYTE.
- wmst_done  in  1  write master finished.
- m_tvalid  out  1  packed word valid.
- m_tdata  out  DATA_WIDTH  packed word.
- m_tready  in  1  downstream ready.
- busy  out  1  high from op_start accept to done.
- done  out  1  one-cycle completion pulse.

## Operation
- State machine states: IDLE, REQ, PACK, WAIT_DONE, FIN.
- IDLE: on op_start, latch addr and count, compute word count and xfer size. If count==0, go to FIN. Otherwise go to REQ. op_start is ignored in every state other than IDLE.
- REQ (one cycle): wmst_req=1, then go to PACK.
- PACK:
  - res_ready = (results_remaining!=0) && (!m_tvalid || m_tready).
  - On a res handshake, write res_data into lane lane_idx of the pack buffer (lane 0 = bits [RES_WIDTH-1:0], LSB-first), increment lane_idx and decrement results_remaining.
  - A word is complete when lane_idx==LANES-1 or results_remaining==1.
  - On completion, copy the pack buffer with the new lane merged in, and all higher lanes zero-padded, into the output register in the same cycle. Set m_tvalid, reset lane_idx to 0 and clear the pack buffer.
  - m_tvalid clears on m_tready unless a new word completes that same cycle, in which case it stays 1 with the new data.
  - When words_remaining reaches 0 on an output handshake, go to WAIT_DONE.
- WAIT_DONE: on wmst_done, go to FIN.
- FIN (one cycle): done=1, then go to IDLE.
- busy = state!=IDLE.
- Arithmetic:
  - words = (count + LANES-1)/LANES, computed in 33 bits so count=2^32-1 does not overflow.
  - xfer_size = words*WORD_BYTE, zero-extended to 64 bits.
- wmst_xfer_addr and wmst_xfer_size hold their values from latch until the next accepted op_start.
- wmst_done arriving before the last word handshake is held in a sticky flag and consumed in WAIT_DONE.

## Timing
- Reset values: all outputs 0, state IDLE, pack buffer 0, m_tdata 0.
- op_start at cycle T gives wmst_req=1 at T+1 only. res_ready can first be high at T+2.
- Throughput is one result per cycle. A completed word appears on m_tvalid in the cycle after its last result handshake.
- Backpressure: while m_tvalid && !m_tready, res_ready=0. m_tdata is stable while m_tvalid is high and not yet accepted.
- Last output handshake at cycle L with wmst_done already seen: WAIT_DONE at L+1, done at L+2 (immediate exit), or later if wmst_done arrives later.
- count==0: op_start at T gives done=1 at T+1 (FIN). No wmst_req is issued and no beats are sent.
- Reset asserted mid-operation: everything returns to reset values immediately, and any partial word is discarded.

## Test plan
- count=32, addr=0x1000, results 0..31, m_tready=1 -> wmst_req at T+1, addr 0x1000, size 128. Two beats: word0 lanes 0..15, word1 lanes 16..31. Then wmst_done -> done one cycle later.
- count=20 -> size 128. Word1 lanes 0..3 = results 16..19 and lanes 4..15 = 0.
- count=48 with m_tready toggling 1/0 every other cycle -> no result lost or duplicated, m_tdata stable while stalled, res_ready low during each stall.
- count=0 -> done at T+1, wmst_req never asserted, m_tvalid never asserted.
- Second op_start while in PACK -> ignored, and latched addr/size unchanged.
- areset_n pulsed low mid-PACK after 5 results -> all outputs 0. A new run with count=16 then produces exactly one correct word.

Source files
------------

// File: rtl/wmst_result_packer.sv
// wmst_result_packer: gathers RES_WIDTH-bit conv results into DATA_WIDTH-bit
// AXI-Stream words, issues the one-shot write-master request for the output
// tensor and pulses done once the write master reports completion.
module wmst_result_packer #(
    parameter int DATA_WIDTH = 512,
    parameter int RES_WIDTH  = 32,
    parameter int LANES      = DATA_WIDTH / RES_WIDTH,
    parameter int WORD_BYTE  = DATA_WIDTH / 8
) (
    input  logic                  aclk,
    input  logic                  areset_n,
    input  logic                  op_start,
    input  logic [63:0]           cfg_out_addr,
    input  logic [31:0]           cfg_out_count,
    input  logic                  res_valid,
    input  logic [RES_WIDTH-1:0]  res_data,
    output logic                  res_ready,
    output logic                  wmst_req,
    output logic [63:0]           wmst_xfer_addr,
    output logic [63:0]           wmst_xfer_size,
    input  logic                  wmst_done,
    output logic                  m_tvalid,
    output logic [DATA_WIDTH-1:0] m_tdata,
    input  logic                  m_tready,
    output logic                  busy,
    output logic                  done
);

    localparam int LIDX_W = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_PACK,
        S_WAIT_DONE,
        S_FIN
    } state_t;

    typedef logic [LANES-1:0][RES_WIDTH-1:0] lanes_t;

    state_t            state_q, state_d;
    logic [63:0]       addr_q, addr_d;
    logic [63:0]       size_q, size_d;
    logic [31:0]       res_rem_q, res_rem_d;
    logic [32:0]       words_rem_q, words_rem_d;
    logic [LIDX_W-1:0] lane_idx_q, lane_idx_d;
    lanes_t            pack_q, pack_d;
    lanes_t            tdata_q, tdata_d;
    logic              tvalid_q, tvalid_d;
    logic              done_seen_q, done_seen_d;

    lanes_t            merged;
    logic [32:0]       words_calc;
    logic              res_hs, out_hs, word_done;

    // Word count is widened to 33 bits so an all-ones result count cannot wrap.
    assign words_calc = ({1'b0, cfg_out_count} + 33'(LANES - 1)) / 33'(LANES);

    // A new result is only taken when the output register is free or draining
    // this cycle, so a completed word never overwrites an unaccepted one.
    assign res_ready = (state_q == S_PACK) && (res_rem_q != '0) && (!tvalid_q || m_tready);
    assign res_hs    = res_valid && res_ready;
    assign out_hs    = tvalid_q && m_tready;
    assign word_done = res_hs && ((lane_idx_q == LIDX_W'(LANES - 1)) || (res_rem_q == 32'd1));

    assign wmst_req       = (state_q == S_REQ);
    assign done           = (state_q == S_FIN);
    assign busy           = (state_q != S_IDLE);
    assign wmst_xfer_addr = addr_q;
    assign wmst_xfer_size = size_q;
    assign m_tvalid       = tvalid_q;
    assign m_tdata        = tdata_q;

    // Pack buffer with the incoming result dropped into its lane; lanes above
    // are already zero because the buffer is cleared after every word.
    always_comb begin
        merged             = pack_q;
        merged[lane_idx_q] = res_data;
    end

    // Next-state and datapath updates for the packer control FSM.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        size_d      = size_q;
        res_rem_d   = res_rem_q;
        words_rem_d = words_rem_q;
        lane_idx_d  = lane_idx_q;
        pack_d      = pack_q;
        tdata_d     = tdata_q;
        tvalid_d    = tvalid_q;
        done_seen_d = done_seen_q;

        case (state_q)
            S_IDLE: begin
                if (op_start) begin
                    addr_d      = cfg_out_addr;
                    size_d      = 64'(words_calc) * 64'(WORD_BYTE);
                    res_rem_d   = cfg_out_count;
                    words_rem_d = words_calc;
                    lane_idx_d  = '0;
                    pack_d      = '0;
                    done_seen_d = 1'b0;
                    state_d     = (cfg_out_count == '0) ? S_FIN : S_REQ;
                end
            end
            S_REQ: begin
                if (wmst_done) done_seen_d = 1'b1;
                state_d = S_PACK;
            end
            S_PACK: begin
                // The write master may finish before our last beat is seen.
                if (wmst_done) done_seen_d = 1'b1;
                if (res_hs) begin
                    res_rem_d = res_rem_q - 32'd1;
                    if (word_done) begin
                        tdata_d    = merged;
                        pack_d     = '0;
                        lane_idx_d = '0;
                    end else begin
                        pack_d     = merged;
                        lane_idx_d = lane_idx_q + 1'b1;
                    end
                end
                if (word_done)   tvalid_d = 1'b1;
                else if (out_hs) tvalid_d = 1'b0;
                if (out_hs) begin
                    words_rem_d = words_rem_q - 33'd1;
                    if (words_rem_q == 33'd1) state_d = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (wmst_done || done_seen_q) state_d = S_FIN;
            end
            S_FIN: begin
                done_seen_d = 1'b0;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset discards any partial word.
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            size_q      <= '0;
            res_rem_q   <= '0;
            words_rem_q <= '0;
            lane_idx_q  <= '0;
            pack_q      <= '0;
            tdata_q     <= '0;
            tvalid_q    <= 1'b0;
            done_seen_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            size_q      <= size_d;
            res_rem_q   <= res_rem_d;
            words_rem_q <= words_rem_d;
            lane_idx_q  <= lane_idx_d;
            pack_q      <= pack_d;
            tdata_q     <= tdata_d;
            tvalid_q    <= tvalid_d;
            done_seen_q <= done_seen_d;
        end
    end

endmodule
